// File: rtl/gumnut_port_timer.sv
// Port-bus timer responder: 5-register window with a prescaled down-counter and interrupt request.
// Latency: one wait state; port_ack_o rises one cycle after a selected strobe. Read data is registered with the ack.
// Backpressure: a held strobe is acked every other cycle; unselected cycles get no ack and drive zero data.
module gumnut_port_timer #(
    parameter logic [7:0] BASE_ADDR  = 8'h10,
    parameter logic [7:0] RST_RELOAD = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       port_cyc_i,
    input  logic       port_stb_i,
    input  logic       port_we_i,
    input  logic [7:0] port_adr_i,
    input  logic [7:0] port_dat_i,
    output logic [7:0] port_dat_o,
    output logic       port_ack_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    output logic       expire_o
);

    // Address decode: the window is BASE_ADDR..BASE_ADDR+4
    logic [7:0] offset;
    logic       sel;
    logic       start;
    logic       wr;
    logic       rd;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_reload;
    logic       wr_prescale;

    assign offset      = port_adr_i - BASE_ADDR;
    assign sel         = port_cyc_i & port_stb_i & (offset < 8'd5);
    // A transfer starts only when no ack is pending, giving the single wait state
    assign start       = sel & ~port_ack_o;
    assign wr          = start & port_we_i;
    assign rd          = start & ~port_we_i;
    assign wr_ctrl     = wr & (offset == 8'd0);
    assign wr_status   = wr & (offset == 8'd1);
    assign wr_reload   = wr & (offset == 8'd2);
    assign wr_prescale = wr & (offset == 8'd4);

    // Timer state
    logic       en;
    logic       ie;
    logic       auto_rl;
    logic       exp_flag;
    logic [7:0] reload;
    logic [7:0] count;
    logic [7:0] prescale;
    logic [7:0] pcnt;
    logic       tick;
    logic       expiry;
    logic [7:0] rdata;

    assign tick   = en & (pcnt == prescale);
    assign expiry = tick & (count == 8'd0);

    // Read mux of the register bank, sampled at the edge that raises the ack
    always_comb begin
        rdata = 8'h00;
        case (offset)
            8'd0:    rdata = {5'b0, auto_rl, ie, en};
            8'd1:    rdata = {7'b0, exp_flag};
            8'd2:    rdata = reload;
            8'd3:    rdata = count;
            8'd4:    rdata = prescale;
            default: rdata = 8'h00;
        endcase
    end

    // Bus handshake: registered ack and read data, zero data whenever not acking a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_ack_o <= 1'b0;
            port_dat_o <= 8'h00;
        end else begin
            port_ack_o <= start;
            port_dat_o <= rd ? rdata : 8'h00;
        end
    end

    // Prescaler: free-runs while enabled, restarts on RELOAD write or on enabling the timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= 8'h00;
        end else if (wr_reload || (wr_ctrl && port_dat_i[0] && !en)) begin
            pcnt <= 8'h00;
        end else if (en) begin
            pcnt <= tick ? 8'h00 : pcnt + 8'd1;
        end
    end

    // Down-counter and RELOAD/PRESCALE registers; a RELOAD write overrides the tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload   <= RST_RELOAD;
            count    <= RST_RELOAD;
            prescale <= 8'h00;
        end else begin
            if (wr_reload) begin
                reload <= port_dat_i;
                count  <= port_dat_i;
            end else if (tick) begin
                if (count != 8'd0)
                    count <= count - 8'd1;
                else if (auto_rl)
                    count <= reload;
            end
            if (wr_prescale)
                prescale <= port_dat_i;
        end
    end

    // Control and status: the tick always sees the old AUTO; one-shot expiry stops the timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            auto_rl  <= 1'b0;
            exp_flag <= 1'b0;
            expire_o <= 1'b0;
        end else begin
            expire_o <= expiry;
            if (wr_ctrl)
                {auto_rl, ie, en} <= port_dat_i[2:0];
            else if (expiry && !auto_rl)
                en <= 1'b0;
            // Setting the flag wins over a simultaneous write-1-clear
            if (expiry)
                exp_flag <= 1'b1;
            else if (wr_status && port_dat_i[0])
                exp_flag <= 1'b0;
        end
    end

    // Interrupt request: raised the edge after an expiry, dropped by int_ack or by clearing IE
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            int_req_o <= 1'b0;
        else if (wr_ctrl && !port_dat_i[1])
            int_req_o <= 1'b0;
        else if (expire_o && ie)
            int_req_o <= 1'b1;
        else if (int_ack_i)
            int_req_o <= 1'b0;
    end

endmodule

// File: tb/tb_gumnut_port_timer.sv
// Bench for gumnut_port_timer: register access table plus timed sequences for timer and interrupt corners.
// Read data expectations are queued at stimulus time and popped when the ack appears.
// Every wait on the DUT is bounded; a global watchdog stops a runaway simulation.
module tb_gumnut_port_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       port_cyc_i;
    logic       port_stb_i;
    logic       port_we_i;
    logic [7:0] port_adr_i;
    logic [7:0] port_dat_i;
    logic [7:0] port_dat_o;
    logic       port_ack_o;
    logic       int_req_o;
    logic       int_ack_i;
    logic       expire_o;

    gumnut_port_timer #(.BASE_ADDR(8'h10), .RST_RELOAD(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .port_cyc_i (port_cyc_i),
        .port_stb_i (port_stb_i),
        .port_we_i  (port_we_i),
        .port_adr_i (port_adr_i),
        .port_dat_i (port_dat_i),
        .port_dat_o (port_dat_o),
        .port_ack_o (port_ack_o),
        .int_req_o  (int_req_o),
        .int_ack_i  (int_ack_i),
        .expire_o   (expire_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] wdat;
        logic       ack;
        logic [7:0] rdat;
    } vec_t;

    localparam logic [7:0] A_CTRL = 8'h10;
    localparam logic [7:0] A_STAT = 8'h11;
    localparam logic [7:0] A_RELD = 8'h12;
    localparam logic [7:0] A_CNT  = 8'h13;
    localparam logic [7:0] A_PRE  = 8'h14;

    vec_t       tbl[24];
    logic [7:0] sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_n = 0;
    int         commit_cyc = 0;
    int         ref_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    // Advance one clock and sample #1 after the edge; acked reads are scored here
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        if (port_ack_o) begin
            if (sb_q.size() == 0)
                chk("unexpected_ack", port_ack_o, 1'b0);
            else
                chk("ack_dat", port_dat_o, sb_q.pop_front());
        end else begin
            chk("idle_dat", port_dat_o, 8'h00);
        end
    endtask

    task automatic drive_bus(input logic we, input logic [7:0] adr, input logic [7:0] wdat);
        port_cyc_i = 1'b1;
        port_stb_i = 1'b1;
        port_we_i  = we;
        port_adr_i = adr;
        port_dat_i = wdat;
    endtask

    task automatic idle_bus();
        port_cyc_i = 1'b0;
        port_stb_i = 1'b0;
        port_we_i  = 1'b0;
        port_adr_i = 8'h00;
        port_dat_i = 8'h00;
    endtask

    // One single-strobe transfer: ack expected in the first cycle only
    task automatic apply_vec(input vec_t v);
        drive_bus(v.we, v.adr, v.wdat);
        if (v.ack)
            sb_q.push_back(v.we ? 8'h00 : v.rdat);
        tick();
        commit_cyc = cyc_n;
        chk("ack", port_ack_o, v.ack);
        idle_bus();
        tick();
        chk("ack_drop", port_ack_o, 1'b0);
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [7:0] d);
        vec_t v;
        v = '{1'b1, adr, d, 1'b1, 8'h00};
        apply_vec(v);
    endtask

    task automatic bus_read(input logic [7:0] adr, input logic [7:0] d);
        vec_t v;
        v = '{1'b0, adr, 8'h00, 1'b1, d};
        apply_vec(v);
    endtask

    task automatic wait_expire(input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = expire_o;
        end
        chk("expire_wait", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        tbl[0]  = '{1'b0, A_RELD, 8'h00, 1'b1, 8'hFF};
        tbl[1]  = '{1'b0, A_CNT,  8'h00, 1'b1, 8'hFF};
        tbl[2]  = '{1'b0, A_CTRL, 8'h00, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, A_STAT, 8'h00, 1'b1, 8'h00};
        tbl[4]  = '{1'b0, A_PRE,  8'h00, 1'b1, 8'h00};
        tbl[5]  = '{1'b1, A_CTRL, 8'hFE, 1'b1, 8'h00};
        tbl[6]  = '{1'b0, A_CTRL, 8'h00, 1'b1, 8'h06};
        tbl[7]  = '{1'b1, A_PRE,  8'h5A, 1'b1, 8'h00};
        tbl[8]  = '{1'b0, A_PRE,  8'h00, 1'b1, 8'h5A};
        tbl[9]  = '{1'b1, A_RELD, 8'h07, 1'b1, 8'h00};
        tbl[10] = '{1'b0, A_CNT,  8'h00, 1'b1, 8'h07};
        tbl[11] = '{1'b1, A_CNT,  8'h33, 1'b1, 8'h00};
        tbl[12] = '{1'b0, A_CNT,  8'h00, 1'b1, 8'h07};
        tbl[13] = '{1'b0, 8'h0F,  8'h00, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 8'h15,  8'h00, 1'b0, 8'h00};
        tbl[15] = '{1'b1, 8'h15,  8'hAA, 1'b0, 8'h00};
        tbl[16] = '{1'b1, 8'h0F,  8'h07, 1'b0, 8'h00};
        tbl[17] = '{1'b0, A_RELD, 8'h00, 1'b1, 8'h07};
        tbl[18] = '{1'b0, A_CTRL, 8'h00, 1'b1, 8'h06};
        tbl[19] = '{1'b1, A_STAT, 8'h00, 1'b1, 8'h00};
        tbl[20] = '{1'b0, A_STAT, 8'h00, 1'b1, 8'h00};
        tbl[21] = '{1'b1, A_CTRL, 8'h00, 1'b1, 8'h00};
        tbl[22] = '{1'b0, A_CTRL, 8'h00, 1'b1, 8'h00};
        tbl[23] = '{1'b0, A_CNT,  8'h00, 1'b1, 8'h07};

        // Reset state
        rst = 1'b1;
        int_ack_i = 1'b0;
        idle_bus();
        #22;
        chk("rst_ack", port_ack_o, 1'b0);
        chk("rst_dat", port_dat_o, 8'h00);
        chk("rst_int", int_req_o, 1'b0);
        chk("rst_exp", expire_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Register access table
        for (int i = 0; i < 24; i++)
            apply_vec(tbl[i]);

        // Out-of-window read held for 10 cycles
        drive_bus(1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("oow_ack", port_ack_o, 1'b0);
        end
        idle_bus();

        // Auto-reload timer: RELOAD=3, PRESCALE=1 gives an 8-cycle period
        bus_write(A_RELD, 8'd3);
        bus_write(A_PRE, 8'd1);
        bus_write(A_CTRL, 8'h07);
        wait_expire(20);
        chk("first_period", cyc_n - commit_cyc, 8);
        chk("int_before", int_req_o, 1'b0);
        ref_cyc = cyc_n;
        tick();
        chk("int_rise", int_req_o, 1'b1);
        chk("exp_pulse_width", expire_o, 1'b0);
        wait_expire(20);
        chk("period", cyc_n - ref_cyc, 8);

        // Held strobe on COUNT across one period: acks every other cycle, 3,2,1,0
        drive_bus(1'b0, A_CNT, 8'h00);
        sb_q.push_back(8'd3);
        sb_q.push_back(8'd2);
        sb_q.push_back(8'd1);
        sb_q.push_back(8'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("held_ack", port_ack_o, logic'(k % 2));
        end
        idle_bus();
        tick();
        chk("held_ack_end", port_ack_o, 1'b0);
        chk("exp_in_phase", expire_o, 1'b1);

        // int_ack in the expiry pulse cycle: request stays set
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
        chk("int_ack_vs_exp", int_req_o, 1'b1);
        // int_ack alone clears the request; EXP survives
        int_ack_i = 1'b1;
        tick();
        int_ack_i = 1'b0;
        chk("int_ack_clear", int_req_o, 1'b0);
        bus_read(A_STAT, 8'h01);
        bus_write(A_STAT, 8'h01);
        bus_read(A_STAT, 8'h00);

        // STATUS clear landing on an expiry edge: EXP stays set
        wait_expire(20);
        for (int i = 0; i < 7; i++)
            tick();
        drive_bus(1'b1, A_STAT, 8'h01);
        sb_q.push_back(8'h00);
        tick();
        chk("clr_ack", port_ack_o, 1'b1);
        chk("clr_on_expiry", expire_o, 1'b1);
        idle_bus();
        tick();
        bus_read(A_STAT, 8'h01);

        // One-shot: AUTO=0, RELOAD=2, PRESCALE=0
        bus_write(A_CTRL, 8'h00);
        chk("ie_off_clears_int", int_req_o, 1'b0);
        bus_write(A_STAT, 8'h01);
        bus_write(A_RELD, 8'd2);
        bus_write(A_PRE, 8'd0);
        bus_write(A_CTRL, 8'h01);
        wait_expire(10);
        chk("oneshot_delay", cyc_n - commit_cyc, 3);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | expire_o | int_req_o;
        end
        chk("oneshot_quiet", seen, 1'b0);
        bus_read(A_CTRL, 8'h00);
        bus_read(A_CNT, 8'h00);
        bus_read(A_STAT, 8'h01);

        // Reset mid-period with an interrupt pending and an ack on the bus
        bus_write(A_RELD, 8'd1);
        bus_write(A_CTRL, 8'h07);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = int_req_o;
        end
        chk("int_wait", seen, 1'b1);
        drive_bus(1'b0, A_RELD, 8'h00);
        sb_q.push_back(8'd1);
        tick();
        chk("pre_rst_ack", port_ack_o, 1'b1);
        chk("pre_rst_int", int_req_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ack", port_ack_o, 1'b0);
        chk("arst_dat", port_dat_o, 8'h00);
        chk("arst_int", int_req_o, 1'b0);
        chk("arst_exp", expire_o, 1'b0);
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_CNT, 8'hFF);
        bus_read(A_RELD, 8'hFF);
        bus_read(A_CTRL, 8'h00);

        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
